// File: rtl/imem_load_arbiter_if.sv
// Loader-side handshake bundle for imem_load_arbiter (master = loader, slave = arbiter).
// IMEM_LD_CHECKSUM_EN adds the ld_csum return signal.
interface imem_load_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;
`ifdef IMEM_LD_CHECKSUM_EN
    logic [31:0]       ld_csum;

    modport master (
        output ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  ld_ready, ld_busy, ld_done, ld_err, ld_csum
    );
    modport slave (
        input  ld_start, ld_base, ld_count, ld_valid, ld_data,
        output ld_ready, ld_busy, ld_done, ld_err, ld_csum
    );
`else
    modport master (
        output ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  ld_ready, ld_busy, ld_done, ld_err
    );
    modport slave (
        input  ld_start, ld_base, ld_count, ld_valid, ld_data,
        output ld_ready, ld_busy, ld_done, ld_err
    );
`endif
endinterface

// File: rtl/imem_load_arbiter.sv
// Purpose: shares the instruction-memory port between CPU fetch and a program loader; optional IMEM_LD_CHECKSUM_EN.
// Latency: CPU fetch is a zero-cycle passthrough in RUN; each accepted loader word is written in its handshake cycle.
// Backpressure: ld_ready is high for the whole LOAD phase; the loader may hold ld_valid low indefinitely.
module imem_load_arbiter #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 1024,
    parameter int          HOLD_CYC = 4,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    output logic              cpu_rst_o,
    imem_load_arbiter_if.slave ld,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   remaining;
    logic [HOLD_W-1:0] hold_cnt;
    logic              ld_err_q;
    logic              ld_done_q;
    logic              hs;
    logic [ADDR_W-1:0] wptr_nxt;
    logic [ADDR_W-1:0] pc_idx;

    assign pc_idx   = cpu_pc[ADDR_W+1:2];
    assign hs       = (state == S_LOAD) && ld.ld_valid;
    // Explicit wrap keeps the pointer legal even if DEPTH is not a power of two.
    assign wptr_nxt = (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + ADDR_W'(1);

    wire unused_pc = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

`ifdef IMEM_LD_CHECKSUM_EN
    logic [31:0] csum;
    assign ld.ld_csum = csum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            wptr      <= '0;
            remaining <= '0;
            hold_cnt  <= '0;
            ld_err_q  <= 1'b0;
            ld_done_q <= 1'b0;
`ifdef IMEM_LD_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            ld_done_q <= 1'b0;
            case (state)
                S_RUN: begin
                    if (ld.ld_start) begin
                        ld_err_q <= 1'b0;
`ifdef IMEM_LD_CHECKSUM_EN
                        csum     <= '0;
`endif
                        if (ld.ld_count == '0) begin
                            ld_done_q <= 1'b1;
                        end else begin
                            wptr      <= ld.ld_base;
                            remaining <= ld.ld_count;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (ld.ld_start) ld_err_q <= 1'b1;
                    if (hs) begin
                        wptr      <= wptr_nxt;
                        remaining <= remaining - (ADDR_W + 1)'(1);
`ifdef IMEM_LD_CHECKSUM_EN
                        csum      <= csum + ld.ld_data;
`endif
                        if (remaining == (ADDR_W + 1)'(1)) begin
                            state    <= S_HOLD;
                            hold_cnt <= HOLD_W'(HOLD_CYC);
                        end
                    end
                end
                S_HOLD: begin
                    if (ld.ld_start) ld_err_q <= 1'b1;
                    // Last hold cycle: done pulses in the first RUN cycle.
                    if (hold_cnt == HOLD_W'(1)) begin
                        state     <= S_RUN;
                        hold_cnt  <= '0;
                        ld_done_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign cpu_instr   = (state == S_RUN) ? mem_rdata : NOP_WORD;
    assign cpu_stall   = (state != S_RUN);
    assign cpu_rst_o   = (state == S_HOLD);
    assign mem_addr    = (state == S_LOAD) ? wptr : pc_idx;
    assign mem_we      = hs;
    assign mem_wdata   = ld.ld_data;
    assign ld.ld_ready = (state == S_LOAD);
    assign ld.ld_busy  = (state != S_RUN);
    assign ld.ld_done  = ld_done_q;
    assign ld.ld_err   = ld_err_q;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: behavioural memory, write scoreboard, readback through the CPU path.
module tb_imem_load_arbiter;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        cpu_rst_o;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic [41:0] exp_q [$];
    logic [9:0]  cur_addr;
    int          tests = 0;
    int          fails = 0;
    int          rst_cyc;
    int          done_cnt;
    logic [31:0] csum_seen;

    imem_load_arbiter_if #(.ADDR_W(10)) ldif ();

    imem_load_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_pc    (cpu_pc),
        .cpu_instr (cpu_instr),
        .cpu_stall (cpu_stall),
        .cpu_rst_o (cpu_rst_o),
        .ld        (ldif),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            chk("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                logic [41:0] e;
                e = exp_q.pop_front();
                chk("sb_addr", {22'd0, mem_addr}, {22'd0, e[41:32]});
                chk("sb_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [9:0] base, input logic [10:0] cnt);
        ldif.ld_start = 1'b1;
        ldif.ld_base  = base;
        ldif.ld_count = cnt;
        tick();
        ldif.ld_start = 1'b0;
        cur_addr      = base;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        ldif.ld_valid = 1'b0;
        repeat (gap) tick();
        exp_q.push_back({cur_addr, d});
        cur_addr      = cur_addr + 10'd1;
        ldif.ld_valid = 1'b1;
        ldif.ld_data  = d;
        #1;
        chk("load_nop", cpu_instr, NOP);
        tick();
        ldif.ld_valid = 1'b0;
    endtask

    task automatic finish_load();
        rst_cyc   = 0;
        done_cnt  = 0;
        csum_seen = '0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_rst_o) rst_cyc++;
            if (ldif.ld_done) begin
                done_cnt++;
`ifdef IMEM_LD_CHECKSUM_EN
                csum_seen = ldif.ld_csum;
`endif
            end
            tick();
        end
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
        cpu_pc = {20'd0, a, 2'b11};
        #1;
        chk(tag, cpu_instr, exp);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[2] = 32'h00500093;
        rst = 1'b1;
        cpu_pc = '0;
        ldif.ld_start = 1'b0;
        ldif.ld_base  = '0;
        ldif.ld_count = '0;
        ldif.ld_valid = 1'b0;
        ldif.ld_data  = '0;
        #2;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
        chk("rst_ready", {31'd0, ldif.ld_ready}, 32'd0);
        chk("rst_busy", {31'd0, ldif.ld_busy}, 32'd0);
        chk("rst_done", {31'd0, ldif.ld_done}, 32'd0);
        chk("rst_err", {31'd0, ldif.ld_err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // RUN passthrough
        cpu_pc = 32'h8;
        #1;
        chk("run_instr", cpu_instr, 32'h00500093);
        chk("run_addr", {22'd0, mem_addr}, 32'd2);
        chk("run_stall", {31'd0, cpu_stall}, 32'd0);
        chk("run_we", {31'd0, mem_we}, 32'd0);

        // Basic load with valid gaps
        start_load(10'd0, 11'd3);
        chk("load_stall", {31'd0, cpu_stall}, 32'd1);
        chk("load_ready", {31'd0, ldif.ld_ready}, 32'd1);
        chk("load_busy", {31'd0, ldif.ld_busy}, 32'd1);
        chk("gap_we", {31'd0, mem_we}, 32'd0);
        send_word(32'hA, 2);
        send_word(32'hB, 0);
        send_word(32'hC, 3);
        finish_load();
        chk("l1_rst_cycles", rst_cyc, 32'd4);
        chk("l1_done_pulses", done_cnt, 32'd1);
        chk("l1_busy_after", {31'd0, ldif.ld_busy}, 32'd0);
        rd("l1_rd0", 10'd0, 32'hA);
        rd("l1_rd1", 10'd1, 32'hB);
        rd("l1_rd2", 10'd2, 32'hC);

        // Wrap-around
        start_load(10'd1022, 11'd4);
        send_word(32'h11, 0);
        send_word(32'h12, 1);
        send_word(32'h13, 0);
        send_word(32'h14, 0);
        finish_load();
        chk("wr_done_pulses", done_cnt, 32'd1);
        rd("wr_rd1022", 10'd1022, 32'h11);
        rd("wr_rd1023", 10'd1023, 32'h12);
        rd("wr_rd0", 10'd0, 32'h13);
        rd("wr_rd1", 10'd1, 32'h14);
        rd("wr_rd2_kept", 10'd2, 32'hC);

        // ld_start during LOAD flags an error but does not disturb the load
        start_load(10'd10, 11'd2);
        send_word(32'h0000_00E0, 0);
        ldif.ld_start = 1'b1;
        ldif.ld_base  = 10'd500;
        ldif.ld_count = 11'd7;
        tick();
        ldif.ld_start = 1'b0;
        chk("err_set", {31'd0, ldif.ld_err}, 32'd1);
        chk("err_still_load", {31'd0, ldif.ld_ready}, 32'd1);
        send_word(32'h0000_00E1, 0);
        finish_load();
        chk("err_done_pulses", done_cnt, 32'd1);
        chk("err_sticky", {31'd0, ldif.ld_err}, 32'd1);
        rd("err_rd10", 10'd10, 32'hE0);
        rd("err_rd11", 10'd11, 32'hE1);

        // Zero-length load from RUN
        start_load(10'd100, 11'd0);
        chk("zero_done", {31'd0, ldif.ld_done}, 32'd1);
        chk("zero_err_clr", {31'd0, ldif.ld_err}, 32'd0);
        chk("zero_busy", {31'd0, ldif.ld_busy}, 32'd0);
        chk("zero_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        chk("zero_done_once", {31'd0, ldif.ld_done}, 32'd0);

        // Reset mid-load aborts immediately
        start_load(10'd20, 11'd5);
        send_word(32'h0000_0D20, 0);
        send_word(32'h0000_0D21, 0);
        rst = 1'b1;
        #1;
        chk("abort_stall", {31'd0, cpu_stall}, 32'd0);
        chk("abort_busy", {31'd0, ldif.ld_busy}, 32'd0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (ldif.ld_done) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 32'd0);
        rd("abort_rd20", 10'd20, 32'hD20);
        rd("abort_rd21", 10'd21, 32'hD21);
        rd("abort_rd22", 10'd22, 32'h0);

        // Full-depth load starting mid-memory
        start_load(10'd5, 11'd1024);
        for (int k = 0; k < 1024; k++) send_word(32'hA500_0000 | k, 0);
        finish_load();
        chk("full_rst_cycles", rst_cyc, 32'd4);
        chk("full_done_pulses", done_cnt, 32'd1);
        rd("full_rd5", 10'd5, 32'hA500_0000);
        rd("full_rd4", 10'd4, 32'hA500_03FF);
        rd("full_rd1023", 10'd1023, 32'hA500_03FA);

`ifdef IMEM_LD_CHECKSUM_EN
        start_load(10'd30, 11'd2);
        send_word(32'hFFFF_FFFF, 0);
        send_word(32'h0000_0002, 1);
        finish_load();
        chk("csum_done_pulses", done_cnt, 32'd1);
        chk("csum_value", csum_seen, 32'h0000_0001);
`endif

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
